sram_128x4096_req_ctrl: RTL and testbench

Request-side controller that sits directly upstream of the 128x4096 high-speed SRAM macro wrapper. Converts a valid/ready request channel (read or byte-masked write) into the macro's active-low CEN/GWEN/WEN pins. Captures the one-cycle-latency read data Q into a small response FIFO with its own valid/ready handshake. Consumer backpressure therefore never loses read data.

---
 rtl/sram_128x4096_req_ctrl.sv | 113 +++++++++++
 tb/tb_sram_128x4096_req_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_128x4096_req_ctrl.sv
// rtl/sram_128x4096_req_ctrl.sv - valid/ready request front end for the 128x4096 SRAM macro with in-order read response FIFO
// Optional combinational Q-to-response bypass: define SRAM_REQ_CTRL_RD_BYPASS_EN.
module sram_128x4096_req_ctrl #(
   parameter int RSP_DEPTH = 2
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_we,
   input  logic [11:0]  req_addr,
   input  logic [15:0]  req_be,
   input  logic [127:0] req_wdata,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [127:0] rsp_rdata,
   output logic         CEN,
   output logic         GWEN,
   output logic [127:0] WEN,
   output logic [11:0]  A,
   output logic [127:0] D,
   input  logic [127:0] Q
);

   localparam int PW = $clog2(RSP_DEPTH);
   localparam int CW = $clog2(RSP_DEPTH + 1);

   logic [127:0]  fifo_mem [RSP_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          rd_inflight;
   logic [CW:0]   occupancy;
   logic          fire;
   logic          rd_fire;
   logic          fifo_nonempty;
   logic          bypass;
   logic          push;
   logic          pop;

   // A read reserves its FIFO slot at fire time so Q always has somewhere to land.
   assign occupancy     = {1'b0, count} + {{CW{1'b0}}, rd_inflight};
   assign req_ready     = ~RST & (req_we | (occupancy < (CW+1)'(RSP_DEPTH)));
   assign fire          = req_valid & req_ready;
   assign rd_fire       = fire & ~req_we;
   assign fifo_nonempty = (count != '0);

`ifdef SRAM_REQ_CTRL_RD_BYPASS_EN
   assign bypass = rd_inflight & ~fifo_nonempty;
`else
   assign bypass = 1'b0;
`endif

   assign push = rd_inflight & ~(bypass & rsp_ready);
   assign pop  = fifo_nonempty & rsp_ready;

   always_comb begin
      CEN  = 1'b1;
      GWEN = 1'b1;
      WEN  = '1;
      A    = '0;
      D    = '0;
      if (fire) begin
         CEN  = 1'b0;
         GWEN = ~req_we;
         A    = req_addr;
         D    = req_wdata;
         if (req_we) begin
            for (int i = 0; i < 16; i++) begin
               WEN[8*i +: 8] = {8{~req_be[i]}};
            end
         end
      end
   end

   always_comb begin
      rsp_valid = ~RST & (fifo_nonempty | bypass);
      rsp_rdata = '0;
      if (!RST) begin
         rsp_rdata = bypass ? Q : fifo_mem[rd_ptr];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_inflight <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
      end else begin
         rd_inflight <= rd_fire;
         if (push) begin
            wr_ptr <= (wr_ptr == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: count/pointers alone decide what is visible.
   always_ff @(posedge CLK) begin
      if (!RST && push) begin
         fifo_mem[wr_ptr] <= Q;
      end
   end

endmodule

// File: tb/tb_sram_128x4096_req_ctrl.sv
// tb/tb_sram_128x4096_req_ctrl.sv - self-checking bench for sram_128x4096_req_ctrl with SRAM macro model
module tb_sram_128x4096_req_ctrl;

   localparam int DEPTH = 2;

   logic         CLK = 1'b0;
   logic         RST;
   logic         req_valid;
   logic         req_ready;
   logic         req_we;
   logic [11:0]  req_addr;
   logic [15:0]  req_be;
   logic [127:0] req_wdata;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [127:0] rsp_rdata;
   logic         CEN;
   logic         GWEN;
   logic [127:0] WEN;
   logic [11:0]  A;
   logic [127:0] D;
   logic [127:0] Q;

   int checks = 0;
   int failures = 0;

   logic [127:0] sram [4096];
   logic [127:0] ref_mem [4096];
   logic [127:0] exp_q [$];
   logic [127:0] rsp_log [$];
   logic         stalled;
   logic [127:0] stalled_data;

   typedef struct {
      logic         valid;
      logic         we;
      logic [11:0]  addr;
      logic [15:0]  be;
      logic [127:0] wdata;
      logic         exp_cen;
      logic         exp_gwen;
      logic [127:0] exp_wen;
   } vec_t;

   vec_t vecs [8];

   always #5 CLK = ~CLK;

   sram_128x4096_req_ctrl #(.RSP_DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .A(A), .D(D), .Q(Q)
   );

   // Macro model: bit-masked write, registered read data.
   always @(posedge CLK) begin
      if (!CEN) begin
         if (!GWEN) sram[A] <= (sram[A] & WEN) | (D & ~WEN);
         else       Q <= sram[A];
      end
   end

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference: responses are whatever memory held at read-fire time, in fire order.
   task automatic monitor();
      if (RST) begin
         exp_q.delete();
         stalled = 1'b0;
         return;
      end
      if (stalled) begin
         chk("hold_valid", 128'(rsp_valid), 128'(1));
         chk("hold_data", rsp_rdata, stalled_data);
      end
      chk("outstanding_bound", 128'(exp_q.size() <= DEPTH), 128'(1));
      if (exp_q.size() == 0) begin
         chk("spurious_rsp_valid", 128'(rsp_valid), 128'(0));
      end else if (rsp_valid && rsp_ready) begin
         chk("rsp_order", rsp_rdata, exp_q.pop_front());
         rsp_log.push_back(rsp_rdata);
      end
      stalled      = rsp_valid && !rsp_ready;
      stalled_data = rsp_rdata;
      if (req_valid && req_ready) begin
         if (req_we) begin
            for (int i = 0; i < 16; i++)
               if (req_be[i]) ref_mem[req_addr][8*i +: 8] = req_wdata[8*i +: 8];
         end else begin
            exp_q.push_back(ref_mem[req_addr]);
         end
      end
   endtask

   task automatic sample();
      @(negedge CLK);
      monitor();
   endtask

   task automatic adv();
      @(posedge CLK);
      #1;
   endtask

   task automatic step();
      sample();
      adv();
   endtask

   task automatic set_req(input logic v, input logic we, input logic [11:0] a,
                          input logic [15:0] be, input logic [127:0] wd);
      req_valid = v;
      req_we    = we;
      req_addr  = a;
      req_be    = be;
      req_wdata = wd;
   endtask

   task automatic wait_rsp(input string name, input logic [127:0] exp);
      bit got = 0;
      for (int i = 0; i < 8 && !got; i++) begin
         sample();
         if (rsp_valid) begin
            got = 1;
            chk(name, rsp_rdata, exp);
         end
         adv();
      end
      if (!got) chk({name, "_timeout"}, 128'(rsp_valid), 128'(1));
   endtask

   initial begin
      logic [127:0] d1;
      logic [127:0] wen_exp;
      logic [127:0] dat [4];
      int idx;
      int start;
      int fires;

      d1 = 128'h0123456789ABCDEF0123456789ABCDEF;
      for (int i = 0; i < 4096; i++) begin
         sram[i]    = '0;
         ref_mem[i] = '0;
      end
      Q       = '0;
      stalled = 1'b0;
      stalled_data = '0;

      vecs[0] = '{1'b0, 1'b1, 12'h123, 16'hFFFF, rnd128(), 1'b1, 1'b1, '1};
      vecs[1] = '{1'b1, 1'b1, 12'h010, 16'h8001, rnd128(), 1'b0, 1'b0,
                  128'h00FFFFFFFFFFFFFFFFFFFFFFFFFFFF00};
      vecs[2] = '{1'b1, 1'b0, 12'h010, 16'hFFFF, rnd128(), 1'b0, 1'b1, '1};
      vecs[3] = '{1'b1, 1'b1, 12'h011, 16'h00F0, rnd128(), 1'b0, 1'b0,
                  128'hFFFFFFFFFFFFFFFF00000000FFFFFFFF};
      vecs[4] = '{1'b1, 1'b0, 12'h011, 16'h0000, rnd128(), 1'b0, 1'b1, '1};
      vecs[5] = '{1'b1, 1'b1, 12'h020, 16'h0000, rnd128(), 1'b0, 1'b0, '1};
      vecs[6] = '{1'b1, 1'b1, 12'h7FF, 16'hFFFF, rnd128(), 1'b0, 1'b0, '0};
      vecs[7] = '{1'b0, 1'b0, 12'h7FF, 16'hFFFF, rnd128(), 1'b1, 1'b1, '1};

      // Reset values while RST is held, even with a request offered.
      RST = 1'b1;
      rsp_ready = 1'b1;
      set_req(1'b1, 1'b1, 12'h03A, 16'hFFFF, rnd128());
      #1;
      sample();
      chk("rst_req_ready", 128'(req_ready), 128'(0));
      chk("rst_cen", 128'(CEN), 128'(1));
      chk("rst_gwen", 128'(GWEN), 128'(1));
      chk("rst_wen", WEN, '1);
      chk("rst_a", 128'(A), 128'(0));
      chk("rst_d", D, 128'(0));
      chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
      chk("rst_rsp_rdata", rsp_rdata, 128'(0));
      adv();
      RST = 1'b0;
      set_req(1'b0, 1'b0, 12'h0, 16'h0, '0);
      step();

      // Pin mapping table; reads are spaced so a credit is always available.
      for (int v = 0; v < 8; v++) begin
         set_req(vecs[v].valid, vecs[v].we, vecs[v].addr, vecs[v].be, vecs[v].wdata);
         sample();
         chk($sformatf("vec%0d_ready", v), 128'(req_ready), 128'(1));
         chk($sformatf("vec%0d_cen", v), 128'(CEN), 128'(vecs[v].exp_cen));
         chk($sformatf("vec%0d_gwen", v), 128'(GWEN), 128'(vecs[v].exp_gwen));
         chk($sformatf("vec%0d_wen", v), WEN, vecs[v].exp_wen);
         chk($sformatf("vec%0d_a", v), 128'(A), vecs[v].valid ? 128'(vecs[v].addr) : 128'(0));
         chk($sformatf("vec%0d_d", v), D, vecs[v].valid ? vecs[v].wdata : 128'(0));
         adv();
      end
      set_req(1'b0, 1'b0, 12'h0, 16'h0, '0);
      for (int i = 0; i < 4; i++) step();

      // Full write then read-back latency.
      set_req(1'b1, 1'b1, 12'h005, 16'hFFFF, d1);
      sample();
      chk("t1_cen", 128'(CEN), 128'(0));
      chk("t1_gwen", 128'(GWEN), 128'(0));
      chk("t1_wen", WEN, 128'(0));
      chk("t1_a", 128'(A), 128'(12'h005));
      adv();
      set_req(1'b1, 1'b0, 12'h005, 16'h0, '0);
      sample();
      chk("t1_rd_ready", 128'(req_ready), 128'(1));
      adv();
      set_req(1'b0, 1'b0, 12'h0, 16'h0, '0);
      sample();
`ifdef SRAM_REQ_CTRL_RD_BYPASS_EN
      chk("t1_valid_n1", 128'(rsp_valid), 128'(1));
      chk("t1_data_n1", rsp_rdata, d1);
`else
      chk("t1_valid_n1", 128'(rsp_valid), 128'(0));
`endif
      adv();
      sample();
`ifdef SRAM_REQ_CTRL_RD_BYPASS_EN
      chk("t1_valid_n2", 128'(rsp_valid), 128'(0));
`else
      chk("t1_valid_n2", 128'(rsp_valid), 128'(1));
      chk("t1_data_n2", rsp_rdata, d1);
`endif
      adv();
      step();

      // Single-byte write at the top address.
      set_req(1'b1, 1'b1, 12'hFFF, 16'h0001, '1);
      sample();
      wen_exp = ~128'hFF;
      chk("t2_wen", WEN, wen_exp);
      adv();
      set_req(1'b1, 1'b0, 12'hFFF, 16'h0, '0);
      step();
      set_req(1'b0, 1'b0, 12'h0, 16'h0, '0);
      wait_rsp("t2_rdata", 128'hFF);
      step();

      // Backpressure: credits stop reads, writes still pass.
      for (int i = 0; i < 4; i++) begin
         dat[i] = rnd128();
         set_req(1'b1, 1'b1, 12'(i), 16'hFFFF, dat[i]);
         step();
      end
      rsp_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         set_req(1'b1, 1'b0, 12'(idx), 16'h0, '0);
         sample();
         if (req_ready) idx++;
         adv();
      end
      chk("t3_fire_count", 128'(idx), 128'(DEPTH));
      set_req(1'b1, 1'b1, 12'h100, 16'h0000, rnd128());
      sample();
      chk("t3_wr_ready", 128'(req_ready), 128'(1));
      chk("t3_wr_cen", 128'(CEN), 128'(0));
      chk("t3_wr_wen", WEN, '1);
      adv();
      rsp_ready = 1'b1;
      start = rsp_log.size();
      for (int c = 0; c < 20 && (rsp_log.size() - start) < 4; c++) begin
         set_req(idx < 4, 1'b0, 12'(idx), 16'h0, '0);
         sample();
         if (req_valid && req_ready) idx++;
         adv();
      end
      set_req(1'b0, 1'b0, 12'h0, 16'h0, '0);
      chk("t3_resumed", 128'(idx), 128'(4));
      chk("t3_rsp_count", 128'(rsp_log.size() - start), 128'(4));
      if (rsp_log.size() - start == 4)
         for (int i = 0; i < 4; i++) chk($sformatf("t3_data%0d", i), rsp_log[start+i], dat[i]);
      for (int i = 0; i < 3; i++) step();

      // Reset with one FIFO entry and one read in flight.
      rsp_ready = 1'b0;
      set_req(1'b1, 1'b0, 12'h001, 16'h0, '0);
      step();
      set_req(1'b0, 1'b0, 12'h0, 16'h0, '0);
      step();
      step();
      set_req(1'b1, 1'b0, 12'h002, 16'h0, '0);
      sample();
      chk("t5_rd_ready", 128'(req_ready), 128'(1));
      adv();
      RST = 1'b1;
      set_req(1'b1, 1'b1, 12'h040, 16'hFFFF, rnd128());
      sample();
      chk("t5_rsp_valid", 128'(rsp_valid), 128'(0));
      chk("t5_cen", 128'(CEN), 128'(1));
      chk("t5_req_ready", 128'(req_ready), 128'(0));
      chk("t5_rsp_rdata", rsp_rdata, 128'(0));
      adv();
      RST = 1'b0;
      rsp_ready = 1'b1;
      set_req(1'b0, 1'b0, 12'h0, 16'h0, '0);
      for (int i = 0; i < 4; i++) begin
         sample();
         chk("t5_no_stale", 128'(rsp_valid), 128'(0));
         adv();
      end

      // Streaming reads behind a pre-filled entry; pointers wrap repeatedly.
      rsp_ready = 1'b0;
      set_req(1'b1, 1'b0, 12'h000, 16'h0, '0);
      step();
      set_req(1'b0, 1'b0, 12'h0, 16'h0, '0);
      step();
      step();
      rsp_ready = 1'b1;
      start = rsp_log.size();
      fires = 0;
      for (int c = 0; c < 20; c++) begin
         set_req(1'b1, 1'b0, 12'($urandom_range(0, 3)), 16'h0, '0);
         sample();
         if (req_ready) fires++;
         adv();
      end
      set_req(1'b0, 1'b0, 12'h0, 16'h0, '0);
      for (int i = 0; i < 6; i++) step();
      chk("t6_rsp_count", 128'(rsp_log.size() - start), 128'(fires + 1));

      // Random traffic with random backpressure.
      for (int n = 0; n < 1000; n++) begin
         set_req(($urandom() % 4) != 0, $urandom() % 2, 12'($urandom_range(0, 15)),
                 16'($urandom()), rnd128());
         rsp_ready = $urandom() % 2;
         step();
      end
      set_req(1'b0, 1'b0, 12'h0, 16'h0, '0);
      rsp_ready = 1'b1;
      for (int i = 0; i < 8 && exp_q.size() != 0; i++) step();
      chk("rand_drained", 128'(exp_q.size()), 128'(0));
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
